glb_host_loader: RTL and testbench



---
 rtl/glb_host_loader.sv | 183 ++++++++++++++++++
 tb/tb_glb_host_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_host_loader.sv
// glb_host_loader: host-side job sequencer for the accelerator.
// A job descriptor (load region, dump region) is taken on cfg_valid/cfg_ready.
// The sequencer then streams load words from the in_* stream into the GLB
// write port, pulses acc_start, waits for acc_done, and streams the opsum
// region back out of the GLB read port onto the out_* stream.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      descriptor handshake
//   load_base, load_words    load region (byte address, word count)
//   dump_base, dump_words    dump region (byte address, word count)
//   in_valid/in_ready/in_data          host load stream
//   acc_start, acc_done      accelerator start pulse / done level
//   glb_we, glb_w_addr, glb_w_data     GLB write port (registered)
//   glb_re, glb_r_addr, glb_r_data     GLB read port (1-cycle read latency)
//   out_valid/out_ready/out_data/out_last   host dump stream
//   busy, job_done           status: not idle / end-of-job pulse
module glb_host_loader #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ADDR_BITS-1:0] load_base,
  input  logic [LEN_BITS-1:0]  load_words,
  input  logic [ADDR_BITS-1:0] dump_base,
  input  logic [LEN_BITS-1:0]  dump_words,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 acc_start,
  input  logic                 acc_done,
  output logic [3:0]           glb_we,
  output logic [ADDR_BITS-1:0] glb_w_addr,
  output logic [DATA_SIZE-1:0] glb_w_data,
  output logic [3:0]           glb_re,
  output logic [ADDR_BITS-1:0] glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 job_done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DUMP} state_t;

  localparam logic [ADDR_BITS-1:0] WORD_STEP = ADDR_BITS'(4);

  state_t state, next_state;

  logic [ADDR_BITS-1:0] load_addr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [LEN_BITS-1:0]  load_words_q;
  logic [LEN_BITS-1:0]  dump_words_q;
  logic [LEN_BITS-1:0]  load_cnt;
  logic [LEN_BITS-1:0]  rd_cnt;
  logic [LEN_BITS-1:0]  pop_cnt;

  // rd_pend marks the cycle in which glb_r_data carries the word requested
  // by glb_re in the previous cycle.
  logic                 rd_pend;
  logic [DATA_SIZE-1:0] fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_cnt;
  logic [2:0]           occupancy;

  logic load_beat;
  logic load_last;
  logic rd_issue;
  logic pop;
  logic pop_last;

  assign cfg_ready = (state == IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (pop_cnt == dump_words_q - 1'b1);

  assign load_beat = in_ready && in_valid;
  assign load_last = load_beat && (load_cnt == load_words_q - 1'b1);

  // Occupancy counts queued words plus both stages of an outstanding read,
  // so the 2-entry FIFO can never overflow regardless of out_ready.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, glb_re[0]} + {2'b00, rd_pend};
  assign rd_issue  = (state == DUMP) && (rd_cnt != dump_words_q) && (occupancy < 3'd2);
  assign pop       = out_valid && out_ready;
  assign pop_last  = pop && out_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (cfg_valid) next_state = (load_words == '0) ? START : LOAD;
      LOAD:  if (load_last) next_state = START;
      START: next_state = WAIT;
      WAIT:  if (acc_done) next_state = (dump_words_q == '0) ? IDLE : DUMP;
      DUMP:  if (pop_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_addr    <= '0;
      rd_addr      <= '0;
      load_words_q <= '0;
      dump_words_q <= '0;
      load_cnt     <= '0;
      rd_cnt       <= '0;
      pop_cnt      <= '0;
      rd_pend      <= 1'b0;
      fifo_mem[0]  <= '0;
      fifo_mem[1]  <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= '0;
      acc_start    <= 1'b0;
      glb_we       <= '0;
      glb_w_addr   <= '0;
      glb_w_data   <= '0;
      glb_re       <= '0;
      glb_r_addr   <= '0;
      busy         <= 1'b0;
      job_done     <= 1'b0;
    end else begin
      if (state == IDLE && cfg_valid) begin
        load_addr    <= {load_base[ADDR_BITS-1:2], 2'b00};
        rd_addr      <= {dump_base[ADDR_BITS-1:2], 2'b00};
        load_words_q <= load_words;
        dump_words_q <= dump_words;
        load_cnt     <= '0;
        rd_cnt       <= '0;
        pop_cnt      <= '0;
      end

      glb_we <= load_beat ? 4'hF : 4'h0;
      if (load_beat) begin
        glb_w_addr <= load_addr;
        glb_w_data <= in_data;
        load_addr  <= load_addr + WORD_STEP;
        load_cnt   <= load_cnt + 1'b1;
      end

      acc_start <= (state == START);

      glb_re <= rd_issue ? 4'hF : 4'h0;
      if (rd_issue) begin
        glb_r_addr <= rd_addr;
        rd_addr    <= rd_addr + WORD_STEP;
        rd_cnt     <= rd_cnt + 1'b1;
      end

      rd_pend <= glb_re[0];
      if (rd_pend) begin
        fifo_mem[wr_ptr] <= glb_r_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        pop_cnt <= pop_cnt + 1'b1;
      end
      case ({rd_pend, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      busy     <= (next_state != IDLE);
      job_done <= (state != IDLE) && (next_state == IDLE);
    end
  end

endmodule

// File: tb/tb_glb_host_loader.sv
module tb_glb_host_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] load_base = '0;
  logic [15:0] load_words = '0;
  logic [31:0] dump_base = '0;
  logic [15:0] dump_words = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        acc_start;
  logic        acc_done = 1'b0;
  logic [3:0]  glb_we;
  logic [31:0] glb_w_addr;
  logic [31:0] glb_w_data;
  logic [3:0]  glb_re;
  logic [31:0] glb_r_addr;
  logic [31:0] glb_r_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        job_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  glb_host_loader #(.DATA_SIZE(32), .ADDR_BITS(32), .LEN_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .load_base(load_base), .load_words(load_words),
    .dump_base(dump_base), .dump_words(dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .acc_start(acc_start), .acc_done(acc_done),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .job_done(job_done)
  );

  // GLB model: written words read back; unwritten words read as D000_0000|addr.
  logic [31:0] mem [int unsigned];
  always @(posedge clk) begin
    if (glb_we == 4'hF) mem[glb_w_addr] = glb_w_data;
    if (glb_re != 4'h0)
      glb_r_data <= mem.exists(glb_r_addr) ? mem[glb_r_addr] : (32'hD000_0000 | glb_r_addr);
  end

  // Monitor: append-only logs; tests snapshot sizes/counts before a job.
  logic [31:0] wa_q[$], wd_q[$], ra_q[$], od_q[$];
  logic        ol_q[$];
  int starts = 0, dones = 0, reads = 0, pops = 0, occ_viol = 0;
  always @(negedge clk) begin
    if (glb_we != 4'h0) begin wa_q.push_back(glb_w_addr); wd_q.push_back(glb_w_data); end
    if (glb_re != 4'h0) begin ra_q.push_back(glb_r_addr); reads++; end
    if (acc_start) starts++;
    if (job_done) dones++;
    if (reads - pops > 2) occ_viol++;
    if (out_valid && out_ready) begin
      od_q.push_back(out_data); ol_q.push_back(out_last); pops++;
    end
  end

  task automatic send_cfg(input logic [31:0] lb, input logic [15:0] lw,
                          input logic [31:0] db, input logic [15:0] dw);
    @(posedge clk); #1;
    cfg_valid = 1'b1; load_base = lb; load_words = lw; dump_base = db; dump_words = dw;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, output bit ok);
    int unsigned n = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int s0, output bit ok);
    int unsigned n = 0;
    while (starts == s0 && n < 100) begin @(negedge clk); n++; end
    ok = (starts != s0);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; acc_done = 1'b1;
    @(posedge clk); #1; acc_done = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int unsigned n = 0;
    while (dones == d0 && n < 400) begin @(negedge clk); n++; end
    ok = (dones != d0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if ({acc_start, busy, job_done, out_valid, out_last} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {acc_start, busy, job_done, out_valid, out_last}); end
    total++; if ({glb_we, glb_re} !== 8'h00) begin bad++; $display("FAIL reset_en got=%h exp=00", {glb_we, glb_re}); end
    total++; if ({glb_w_addr, glb_w_data, glb_r_addr} !== 96'h0) begin
      bad++; $display("FAIL reset_addr got=%h exp=0", {glb_w_addr, glb_w_data, glb_r_addr}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w0 = wa_q.size(), r0 = ra_q.size(), o0 = od_q.size(), s0 = starts, d0 = dones;
    bit ok, all_ok = 1'b1;
    logic [31:0] exp_wa [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] exp_wd [4] = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
    logic [31:0] exp_ra [3] = '{32'h200, 32'h204, 32'h208};
    logic [31:0] exp_od [3] = '{32'hD000_0200, 32'hD000_0204, 32'hD000_0208};
    logic        exp_ol [3] = '{1'b0, 1'b0, 1'b1};
    send_cfg(32'h100, 16'd4, 32'h200, 16'd3);
    for (int k = 0; k < 4; k++) begin push_word(exp_wd[k], ok); all_ok &= ok; end
    wait_start(s0, ok); all_ok &= ok;
    repeat (9) @(posedge clk);
    pulse_done();
    wait_done(d0, ok); all_ok &= ok;
    @(negedge clk);
    total++; if (!all_ok) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
    total++; if (wa_q.size() - w0 != 4) begin bad++; $display("FAIL basic_wr_count got=%0d exp=4", wa_q.size() - w0); end
    for (int k = 0; k < 4 && w0 + k < wa_q.size(); k++) begin
      total++; if (wa_q[w0+k] !== exp_wa[k] || wd_q[w0+k] !== exp_wd[k]) begin
        bad++; $display("FAIL basic_write%0d got=%h/%h exp=%h/%h", k, wa_q[w0+k], wd_q[w0+k], exp_wa[k], exp_wd[k]); end
    end
    total++; if (starts - s0 != 1) begin bad++; $display("FAIL basic_start_count got=%0d exp=1", starts - s0); end
    total++; if (ra_q.size() - r0 != 3) begin bad++; $display("FAIL basic_rd_count got=%0d exp=3", ra_q.size() - r0); end
    for (int j = 0; j < 3 && r0 + j < ra_q.size(); j++) begin
      total++; if (ra_q[r0+j] !== exp_ra[j]) begin bad++; $display("FAIL basic_rd%0d got=%h exp=%h", j, ra_q[r0+j], exp_ra[j]); end
    end
    total++; if (od_q.size() - o0 != 3) begin bad++; $display("FAIL basic_out_count got=%0d exp=3", od_q.size() - o0); end
    for (int j = 0; j < 3 && o0 + j < od_q.size(); j++) begin
      total++; if (od_q[o0+j] !== exp_od[j] || ol_q[o0+j] !== exp_ol[j]) begin
        bad++; $display("FAIL basic_out%0d got=%h/%b exp=%h/%b", j, od_q[o0+j], ol_q[o0+j], exp_od[j], exp_ol[j]); end
    end
    total++; if (dones - d0 != 1) begin bad++; $display("FAIL basic_job_done got=%0d exp=1", dones - d0); end
    total++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b%b exp=01", busy, cfg_ready); end
  endtask

  task automatic test_gapped_load();
    int w0 = wa_q.size(), o0 = od_q.size(), d0 = dones, s0 = starts;
    bit ok, all_ok = 1'b1;
    int gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 0};
    send_cfg(32'h303, 16'd8, 32'h302, 16'd2);
    for (int k = 0; k < 8; k++) begin
      repeat (gaps[k]) @(posedge clk);
      #1;
      push_word(32'hB000_0000 + k, ok); all_ok &= ok;
    end
    wait_start(s0, ok); all_ok &= ok;
    pulse_done();
    wait_done(d0, ok); all_ok &= ok;
    @(negedge clk);
    total++; if (!all_ok) begin bad++; $display("FAIL gap_timeout got=0 exp=1"); end
    total++; if (wa_q.size() - w0 != 8) begin bad++; $display("FAIL gap_wr_count got=%0d exp=8", wa_q.size() - w0); end
    for (int k = 0; k < 8 && w0 + k < wa_q.size(); k++) begin
      total++; if (wa_q[w0+k] !== 32'h300 + 4*k || wd_q[w0+k] !== 32'hB000_0000 + k) begin
        bad++; $display("FAIL gap_write%0d got=%h/%h exp=%h/%h", k, wa_q[w0+k], wd_q[w0+k], 32'h300 + 4*k, 32'hB000_0000 + k); end
    end
    total++; if (od_q.size() - o0 != 2) begin bad++; $display("FAIL gap_out_count got=%0d exp=2", od_q.size() - o0); end
    else begin
      total++; if (od_q[o0] !== 32'hB000_0000 || od_q[o0+1] !== 32'hB000_0001 || ol_q[o0] !== 1'b0 || ol_q[o0+1] !== 1'b1) begin
        bad++; $display("FAIL gap_readback got=%h,%h last=%b%b exp=b0000000,b0000001 last=01", od_q[o0], od_q[o0+1], ol_q[o0], ol_q[o0+1]); end
    end
  endtask

  task automatic test_back_to_back_dump();
    int r0 = ra_q.size(), o0 = od_q.size(), d0 = dones, s0 = starts, v0 = occ_viol;
    int unsigned n = 0;
    bit ok;
    send_cfg(32'h0, 16'd0, 32'h400, 16'd16);
    wait_start(s0, ok);
    pulse_done();
    while (dones == d0 && n < 400) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (dones - d0 != 1 || !ok) begin bad++; $display("FAIL bp_job_done got=%0d exp=1", dones - d0); end
    total++; if (ra_q.size() - r0 != 16) begin bad++; $display("FAIL bp_rd_count got=%0d exp=16", ra_q.size() - r0); end
    total++; if (od_q.size() - o0 != 16) begin bad++; $display("FAIL bp_out_count got=%0d exp=16", od_q.size() - o0); end
    for (int j = 0; j < 16 && o0 + j < od_q.size(); j++) begin
      total++; if (od_q[o0+j] !== 32'hD000_0400 + 4*j || ol_q[o0+j] !== (j == 15)) begin
        bad++; $display("FAIL bp_out%0d got=%h/%b exp=%h/%b", j, od_q[o0+j], ol_q[o0+j], 32'hD000_0400 + 4*j, j == 15); end
    end
    total++; if (occ_viol != v0) begin bad++; $display("FAIL bp_outstanding got=%0d exp=0 violations", occ_viol - v0); end
  endtask

  task automatic test_zero_job();
    int w0 = wa_q.size(), r0 = ra_q.size(), d0 = dones, s0 = starts;
    bit ok, all_ok = 1'b1;
    send_cfg(32'h800, 16'd0, 32'h900, 16'd0);
    wait_start(s0, ok); all_ok &= ok;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1 || dones != d0) begin bad++; $display("FAIL zero_wait_holds got=busy%b done%0d exp=busy1 done0", busy, dones - d0); end
    pulse_done();
    wait_done(d0, ok); all_ok &= ok;
    @(negedge clk);
    total++; if (!all_ok) begin bad++; $display("FAIL zero_timeout got=0 exp=1"); end
    total++; if (wa_q.size() != w0 || ra_q.size() != r0) begin
      bad++; $display("FAIL zero_no_glb got=%0d/%0d exp=0/0", wa_q.size() - w0, ra_q.size() - r0); end
    total++; if (starts - s0 != 1 || dones - d0 != 1) begin
      bad++; $display("FAIL zero_pulses got=%0d/%0d exp=1/1", starts - s0, dones - d0); end
  endtask

  task automatic test_done_during_load();
    int o0 = od_q.size(), d0 = dones, s0 = starts, w0 = wa_q.size();
    bit ok, all_ok = 1'b1;
    @(posedge clk); #1; acc_done = 1'b1;
    send_cfg(32'h500, 16'd2, 32'h500, 16'd1);
    push_word(32'hC0C0_C0C0, ok); all_ok &= ok;
    repeat (3) @(posedge clk);
    #1; acc_done = 1'b0;
    push_word(32'hC1C1_C1C1, ok); all_ok &= ok;
    wait_start(s0, ok); all_ok &= ok;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1 || dones != d0 || od_q.size() != o0) begin
      bad++; $display("FAIL ddl_wait_holds got=busy%b done%0d out%0d exp=busy1 done0 out0", busy, dones - d0, od_q.size() - o0); end
    pulse_done();
    wait_done(d0, ok); all_ok &= ok;
    @(negedge clk);
    total++; if (!all_ok || wa_q.size() - w0 != 2) begin bad++; $display("FAIL ddl_load got=%0d exp=2", wa_q.size() - w0); end
    total++; if (od_q.size() - o0 != 1) begin bad++; $display("FAIL ddl_out_count got=%0d exp=1", od_q.size() - o0); end
    else begin
      total++; if (od_q[o0] !== 32'hC0C0_C0C0 || ol_q[o0] !== 1'b1) begin
        bad++; $display("FAIL ddl_out got=%h/%b exp=c0c0c0c0/1", od_q[o0], ol_q[o0]); end
    end
  endtask

  task automatic test_reset_mid_dump();
    int o0, d0, s0 = starts, w0;
    int unsigned n = 0;
    bit ok, all_ok = 1'b1;
    out_ready = 1'b0;
    send_cfg(32'h0, 16'd0, 32'h600, 16'd8);
    wait_start(s0, ok); all_ok &= ok;
    pulse_done();
    @(negedge clk);
    while (glb_re == 4'h0 && n < 50) begin @(negedge clk); n++; end
    all_ok &= (glb_re != 4'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (!all_ok) begin bad++; $display("FAIL rmd_setup got=0 exp=1"); end
    total++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      bad++; $display("FAIL rmd_comb got=%b%b%b%b exp=1000", cfg_ready, in_ready, out_valid, out_last); end
    total++; if ({acc_start, busy, job_done, glb_we, glb_re} !== 11'h0) begin
      bad++; $display("FAIL rmd_regs got=%h exp=0", {acc_start, busy, job_done, glb_we, glb_re}); end
    total++; if ({glb_w_addr, glb_w_data, glb_r_addr, out_data} !== 128'h0) begin
      bad++; $display("FAIL rmd_data got=%h exp=0", {glb_w_addr, glb_w_data, glb_r_addr, out_data}); end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    o0 = od_q.size(); d0 = dones; s0 = starts; w0 = wa_q.size();
    send_cfg(32'h700, 16'd1, 32'h700, 16'd1);
    push_word(32'hE0E0_0001, ok); all_ok &= ok;
    wait_start(s0, ok); all_ok &= ok;
    pulse_done();
    wait_done(d0, ok); all_ok &= ok;
    @(negedge clk);
    total++; if (!all_ok || wa_q.size() - w0 != 1) begin bad++; $display("FAIL rmd_rerun_load got=%0d exp=1", wa_q.size() - w0); end
    total++; if (od_q.size() - o0 != 1) begin bad++; $display("FAIL rmd_rerun_count got=%0d exp=1", od_q.size() - o0); end
    else begin
      total++; if (od_q[o0] !== 32'hE0E0_0001 || ol_q[o0] !== 1'b1) begin
        bad++; $display("FAIL rmd_rerun_out got=%h/%b exp=e0e00001/1", od_q[o0], ol_q[o0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped_load();
    test_back_to_back_dump();
    test_zero_job();
    test_done_during_load();
    test_reset_mid_dump();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
